// File: rtl/vga_update_ctrl.sv
// vga_update_ctrl
//   Frame-synchronous update controller between the digit sources and the
//   video generator. It arbitrates round-robin between two requesters
//   (0 = keypad decoder, 1 = host/SPI) and holds one accepted update. That
//   update is committed only at the start of vertical blanking, and only
//   after a minimum number of frames since the previous commit. The block
//   also owns the LFSR that picks the text string for each new digit.
//
// Ports
//   pixClk     pixel clock
//   reset      asynchronous, active-high
//   x, y       pixel / line counters from the VGA driver
//   reqValid   per-requester update request
//   reqDigit0  digit from requester 0
//   reqDigit1  digit from requester 1
//   reqEn      per-requester digit-enable value
//   reqReady   per-requester accept (combinational, held low in reset)
//   digit      committed digit
//   digitEn    committed enable
//   txtSelect  text string index (0 while the digit is disabled)
//   busy       an update is pending
//   commit     one-cycle pulse on each commit
module vga_update_ctrl #(
  parameter int         V_AV        = 480,
  parameter int         HOLD_FRAMES = 2,
  parameter logic [4:0] LFSR_SEED   = 5'h03,
  parameter int         OPTIONS     = 10
) (
  input  logic       pixClk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] reqValid,
  input  logic [3:0] reqDigit0,
  input  logic [3:0] reqDigit1,
  input  logic [1:0] reqEn,
  output logic [1:0] reqReady,
  output logic [3:0] digit,
  output logic       digitEn,
  output logic [3:0] txtSelect,
  output logic       busy,
  output logic       commit
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_FRAMES - 1);
  localparam logic [3:0] TXT_MAX     = 4'(OPTIONS - 1);
  localparam logic [9:0] VBLANK_LINE = 10'(V_AV);

  logic [0:0] state;
  logic [3:0] holdCnt;
  logic [3:0] pendDigit;
  logic       pendEn;
  logic       lastGrant;
  logic [4:0] q;

  logic       vblankStart;
  logic [1:0] grant;
  logic       doCommit;
  logic       lfsrAdvance;

  assign vblankStart = (x == 10'd0) && (y == VBLANK_LINE);

  // On a tie, the requester that was not granted last time wins.
  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (reqValid == 2'b11) grant = lastGrant ? 2'b01 : 2'b10;
      else                   grant = reqValid;
    end
  end

  assign reqReady = reset ? '0 : grant;
  assign busy     = (state == PENDING);
  assign doCommit = (state == PENDING) && vblankStart && (holdCnt == '0);

  // A new text string is only drawn when a visible digit actually changes.
  assign lfsrAdvance = pendEn && ((pendDigit != digit) || !digitEn);

  assign txtSelect = !digitEn ? 4'd0 :
                     ((q[3:0] != 4'd0) && (q[3:0] <= TXT_MAX)) ? q[3:0] : 4'd1;

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      holdCnt   <= '0;
      pendDigit <= '0;
      pendEn    <= 1'b0;
      lastGrant <= 1'b1;
      q         <= LFSR_SEED;
      digit     <= '0;
      digitEn   <= 1'b0;
      commit    <= 1'b0;
    end else begin
      commit <= 1'b0;

      if (doCommit) begin
        holdCnt <= HOLD_RELOAD;
      end else if (vblankStart && (holdCnt != '0)) begin
        holdCnt <= holdCnt - 4'd1;
      end

      case (state)
        IDLE: begin
          if (grant != '0) begin
            pendDigit <= grant[1] ? reqDigit1 : reqDigit0;
            pendEn    <= grant[1] ? reqEn[1]  : reqEn[0];
            lastGrant <= grant[1];
            state     <= PENDING;
          end
        end
        default: begin
          if (doCommit) begin
            digit   <= pendDigit;
            digitEn <= pendEn;
            commit  <= 1'b1;
            if (lfsrAdvance) q <= {q[3:0], q[4] ^ q[2]};
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_update_ctrl.sv
module tb_vga_update_ctrl;

  logic       pixClk;
  logic       reset;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] reqValid;
  logic [3:0] reqDigit0;
  logic [3:0] reqDigit1;
  logic [1:0] reqEn;
  logic [1:0] reqReady;
  logic [3:0] digit;
  logic       digitEn;
  logic [3:0] txtSelect;
  logic       busy;
  logic       commit;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned commitCnt = 0;

  vga_update_ctrl #(
    .V_AV(480),
    .HOLD_FRAMES(2),
    .LFSR_SEED(5'h03),
    .OPTIONS(10)
  ) dut (
    .pixClk(pixClk),
    .reset(reset),
    .x(x),
    .y(y),
    .reqValid(reqValid),
    .reqDigit0(reqDigit0),
    .reqDigit1(reqDigit1),
    .reqEn(reqEn),
    .reqReady(reqReady),
    .digit(digit),
    .digitEn(digitEn),
    .txtSelect(txtSelect),
    .busy(busy),
    .commit(commit)
  );

  initial pixClk = 1'b0;
  always #5 pixClk = ~pixClk;

  always @(negedge pixClk) if (commit) commitCnt <= commitCnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given x/y; afterwards x/y return to a mid-frame spot.
  task automatic tick(input logic [9:0] xi, input logic [9:0] yi);
    x = xi;
    y = yi;
    @(posedge pixClk);
    #1;
    x = 10'd5;
    y = 10'd100;
  endtask

  task automatic bnd();
    tick(10'd0, 10'd480);
  endtask

  task automatic outs(input string tag, input logic [3:0] d, input logic e,
                      input logic [3:0] t, input logic b, input logic c);
    check({tag, ".digit"},   32'(digit),     32'(d));
    check({tag, ".digitEn"}, 32'(digitEn),   32'(e));
    check({tag, ".txt"},     32'(txtSelect), 32'(t));
    check({tag, ".busy"},    32'(busy),      32'(b));
    check({tag, ".commit"},  32'(commit),    32'(c));
  endtask

  initial begin
    reset = 1'b1;
    x = 10'd5;
    y = 10'd100;
    reqValid = 2'b11;
    reqDigit0 = 4'd0;
    reqDigit1 = 4'd0;
    reqEn = 2'b00;
    repeat (3) @(posedge pixClk);
    #1;
    check("ready_in_reset", 32'(reqReady), 32'h0);
    outs("reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    reqValid = 2'b00;
    @(negedge pixClk);
    reset = 1'b0;
    tick(10'd5, 10'd100);

    // Three idle frames
    for (int unsigned i = 0; i < 3; i++) begin
      tick(10'd300, 10'd200);
      bnd();
    end
    outs("idle", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("idle.commits", commitCnt, 0);

    // Request 0: digit 7 accepted mid-frame, committed at the next boundary
    reqValid = 2'b01; reqDigit0 = 4'd7; reqEn = 2'b01;
    #1;
    check("r0.ready", 32'(reqReady), 32'h1);
    tick(10'd200, 10'd150);
    reqValid = 2'b00;
    check("r0.busy", 32'(busy), 32'h1);
    tick(10'd1, 10'd480);
    tick(10'd0, 10'd479);
    tick(10'd0, 10'd481);
    outs("r0.near", 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    bnd();
    outs("r0.commit", 4'd7, 1'b1, 4'd6, 1'b0, 1'b1);
    tick(10'd5, 10'd100);
    check("r0.pulse", 32'(commit), 32'h0);

    // Request 1: digit 2, held off one frame by the hold counter
    reqValid = 2'b10; reqDigit1 = 4'd2; reqEn = 2'b10;
    #1;
    check("r1.ready", 32'(reqReady), 32'h2);
    tick(10'd5, 10'd100);
    reqValid = 2'b00;
    bnd();
    outs("r1.k1", 4'd7, 1'b1, 4'd6, 1'b1, 1'b0);
    bnd();
    outs("r1.k2", 4'd2, 1'b1, 4'd1, 1'b0, 1'b1);

    // Both valid: grants alternate 0,1,0
    reqValid = 2'b11; reqDigit0 = 4'd3; reqDigit1 = 4'd4; reqEn = 2'b11;
    #1;
    check("rr1.ready", 32'(reqReady), 32'h1);
    tick(10'd5, 10'd100);
    check("rr1.busyready", 32'(reqReady), 32'h0);
    reqDigit0 = 4'd4;
    bnd();
    bnd();
    outs("rr1.commit", 4'd3, 1'b1, 4'd1, 1'b0, 1'b1);
    check("rr2.ready", 32'(reqReady), 32'h2);
    tick(10'd5, 10'd100);
    check("rr2.busyready", 32'(reqReady), 32'h0);
    bnd();
    bnd();
    outs("rr2.commit", 4'd4, 1'b1, 4'd7, 1'b0, 1'b1);
    check("rr3.ready", 32'(reqReady), 32'h1);
    tick(10'd5, 10'd100);
    reqValid = 2'b00;
    bnd();
    check("rr3.hold", 32'(commit), 32'h0);
    bnd();
    // Same digit and enable as shown: LFSR stays put
    outs("same.commit", 4'd4, 1'b1, 4'd7, 1'b0, 1'b1);

    // Disable the digit
    reqValid = 2'b01; reqDigit0 = 4'd4; reqEn = 2'b00;
    tick(10'd5, 10'd100);
    reqValid = 2'b00;
    bnd();
    bnd();
    outs("dis.commit", 4'd4, 1'b0, 4'd0, 1'b0, 1'b1);

    // Reset while pending, ten lines before vblank
    reqValid = 2'b01; reqDigit0 = 4'd9; reqEn = 2'b01;
    tick(10'd5, 10'd100);
    reqValid = 2'b00;
    check("rst.busy", 32'(busy), 32'h1);
    x = 10'd0; y = 10'd470;
    reset = 1'b1;
    #1;
    outs("rst.async", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(10'd0, 10'd470);
    @(negedge pixClk);
    reset = 1'b0;
    commitCnt = 0;
    tick(10'd5, 10'd100);
    bnd();
    bnd();
    outs("rst.after", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst.commits", commitCnt, 0);

    // Acceptance coinciding with vblankStart is not committed that frame
    reqValid = 2'b01; reqDigit0 = 4'd5; reqEn = 2'b01;
    bnd();
    reqValid = 2'b00;
    outs("same_cycle", 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    bnd();
    outs("same_cycle.commit", 4'd5, 1'b1, 4'd6, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
